uart_tx_fifo: RTL

//  Transmit byte buffer between the UART CSR block and the serial transmitter.

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the CSR block / serial transmitter (master) and the
// transmit FIFO (slave).
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  flush;
  logic                  ovf_clr;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  clear_req;
  logic                  irq;

  modport master (
    output wr_en, wr_data, flush, ovf_clr, clear_req,
    input  full, empty, level, overflow, tx_data, tx_start, irq
  );

  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, clear_req,
    output full, empty, level, overflow, tx_data, tx_start, irq
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: buffers CSR writes and hands bytes one at a time to the
// serial transmitter. Define UART_TX_FIFO_IRQ_EN for the low-water interrupt.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int LOW_WATER  = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

  if (LOW_WATER < 0 || LOW_WATER > DEPTH) begin : g_bad_low_water
    $error("uart_tx_fifo: LOW_WATER must lie in 0..DEPTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;

  logic                  full, empty;
  logic                  push, drop, load;

  // full/empty come from the pre-edge level, so a pop in the same cycle
  // never rescues a push into a full FIFO.
  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);
  assign push  = bus.wr_en & ~full & ~bus.flush;
  assign drop  = bus.wr_en &  full & ~bus.flush;
  assign load  = (state_q == S_IDLE) & ~empty & ~bus.flush;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.clear_req) begin
          tx_start_d = 1'b0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    // Flush empties the queue only; a byte already presented is untouched.
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (load) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, load})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Storage array carries no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  localparam logic [DEPTH_LOG2:0] LOW_WATER_LVL = (DEPTH_LOG2 + 1)'(LOW_WATER);

  logic irq_q, irq_d;

  assign irq_d = (level_d <= LOW_WATER_LVL);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule
